// File: rtl/logical_arbiter_if.sv
// One requester's port onto the shared logical unit: the op request
// and its one-entry response return path. The master modport is the
// requester side and the slave modport is the arbiter side.
interface logical_arbiter_if #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned OP_WIDTH = 5,
  parameter int unsigned CR_WIDTH = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [OP_WIDTH-1:0] req_op;
  logic [DWIDTH-1:0]   req_a;
  logic [DWIDTH-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DWIDTH-1:0]   rsp_res;
  logic [CR_WIDTH-1:0] rsp_cr;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_cr
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_cr
  );
endinterface

// File: rtl/logical_arbiter.sv
// Shares one combinational logical unit between two requesters.
// Round-robin grant, unit operands steered from the winner, and the
// unit's res/cr captured one cycle later into a per-requester buffer
// that is released with a valid/ready handshake.
module logical_arbiter #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned OP_WIDTH = 5,
  parameter int unsigned CR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  logical_arbiter_if.slave    ch0,
  logical_arbiter_if.slave    ch1,
  output logic [OP_WIDTH-1:0] lu_op,
  output logic [DWIDTH-1:0]   lu_a,
  output logic [DWIDTH-1:0]   lu_b,
  input  logic [DWIDTH-1:0]   lu_res,
  input  logic [CR_WIDTH-1:0] lu_cr
);

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

  grant_e              last_grant_q;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DWIDTH-1:0]   rsp0_res_q;
  logic [DWIDTH-1:0]   rsp1_res_q;
  logic [CR_WIDTH-1:0] rsp0_cr_q;
  logic [CR_WIDTH-1:0] rsp1_cr_q;

  logic elig0, elig1;
  logic grant0, grant1;

  // Eligibility and round-robin grant; everything is forced low while reset is high
  always_comb begin
    elig0  = ~reset & ch0.req_valid & (~rsp0_valid_q | ch0.rsp_ready);
    elig1  = ~reset & ch1.req_valid & (~rsp1_valid_q | ch1.rsp_ready);
    grant0 = elig0 & (~elig1 | (last_grant_q == GRANT_REQ1));
    grant1 = elig1 & (~elig0 | (last_grant_q == GRANT_REQ0));
  end

  // Steer the winner's fields to the unit; all-zero when nobody is granted
  always_comb begin
    lu_op = '0;
    lu_a  = '0;
    lu_b  = '0;
    if (grant0) begin
      lu_op = ch0.req_op;
      lu_a  = ch0.req_a;
      lu_b  = ch0.req_b;
    end else if (grant1) begin
      lu_op = ch1.req_op;
      lu_a  = ch1.req_a;
      lu_b  = ch1.req_b;
    end
  end

  // Response-valid next state: a grant refills, otherwise hold until drained
  always_comb begin
    rsp0_valid_d = grant0 | (rsp0_valid_q & ~ch0.rsp_ready);
    rsp1_valid_d = grant1 | (rsp1_valid_q & ~ch1.rsp_ready);
  end

  // Response buffers and last-grant pointer; data loads only on grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GRANT_REQ1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_res_q   <= '0;
      rsp1_res_q   <= '0;
      rsp0_cr_q    <= '0;
      rsp1_cr_q    <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      if (grant0) begin
        rsp0_res_q   <= lu_res;
        rsp0_cr_q    <= lu_cr;
        last_grant_q <= GRANT_REQ0;
      end
      if (grant1) begin
        rsp1_res_q   <= lu_res;
        rsp1_cr_q    <= lu_cr;
        last_grant_q <= GRANT_REQ1;
      end
    end
  end

  assign ch0.req_ready = grant0;
  assign ch1.req_ready = grant1;
  assign ch0.rsp_valid = rsp0_valid_q;
  assign ch1.rsp_valid = rsp1_valid_q;
  assign ch0.rsp_res   = rsp0_res_q;
  assign ch1.rsp_res   = rsp1_res_q;
  assign ch0.rsp_cr    = rsp0_cr_q;
  assign ch1.rsp_cr    = rsp1_cr_q;

endmodule
